multi_edge_detect: RTL

Parametrised successor to the single-channel asynchronous edge detector. It synchronises CHANNELS asynchronous inputs into the SYNC_CLK_IN domain and debounces each one with a stability filter. Each channel has a selectable edge mode, and the block emits a one-cycle detect pulse per qualified edge. A saturating per-channel event counter and a sticky flag let the GPS front-end and the CPU-facing register logic poll edge activity without missing events.

---
 rtl/edge_detect_pkg.sv | 22 ++
 rtl/multi_edge_detect_if.sv | 27 ++
 rtl/edge_channel.sv | 86 ++++++++
 rtl/multi_edge_detect.sv | 33 +++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared edge-mode constants and helpers for multi_edge_detect
package edge_detect_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/multi_edge_detect_if.sv
// rtl/multi_edge_detect_if.sv - channel input/output bundle for multi_edge_detect
interface multi_edge_detect_if
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
);

  logic [CHANNELS-1:0]           ASYNC_IN;
  logic [2*CHANNELS-1:0]         MODE_IN;
  logic [CHANNELS-1:0]           CLEAR_IN;
  logic [CHANNELS-1:0]           LEVEL_OUT;
  logic [CHANNELS-1:0]           DETECT_OUT;
  logic [CHANNELS-1:0]           SEEN_OUT;
  logic [CHANNELS*CNT_WIDTH-1:0] COUNT_OUT;

  modport master (
    output ASYNC_IN, MODE_IN, CLEAR_IN,
    input  LEVEL_OUT, DETECT_OUT, SEEN_OUT, COUNT_OUT
  );

  modport slave (
    input  ASYNC_IN, MODE_IN, CLEAR_IN,
    output LEVEL_OUT, DETECT_OUT, SEEN_OUT, COUNT_OUT
  );

endinterface

// File: rtl/edge_channel.sv
// rtl/edge_channel.sv - one channel: synchroniser, stability filter, edge qualify, counter, sticky flag
module edge_channel
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 async_in,
  input  logic [1:0]           mode,
  input  logic                 clear,
  output logic                 level,
  output logic                 detect,
  output logic                 seen,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int                   FW      = clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]        FLIP_AT = FW'(FILTER_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;
  logic [FW-1:0]          fcnt;
  logic                   flip;
  logic                   qualified;
  logic                   event_q;

  assign sync_q = sync_chain[SYNC_STAGES-1];
  assign flip   = (sync_q != level) && (fcnt == FLIP_AT);

  // A flip is reported only when the current mode enables that direction;
  // the new level equals sync_q, so sync_q tells rise from fall.
  always_comb begin
    qualified = 1'b0;
    if (sync_q) qualified = (mode & EDGE_RISE) != EDGE_OFF;
    else        qualified = (mode & EDGE_FALL) != EDGE_OFF;
  end

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!resetn) sync_chain <= '0;
    else         sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
  end

  // Stability filter: level follows sync_q only after FILTER_LEN differing cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      level   <= 1'b0;
      fcnt    <= '0;
      event_q <= 1'b0;
    end else begin
      event_q <= flip && qualified;
      if (sync_q == level) begin
        fcnt <= '0;
      end else if (flip) begin
        level <= sync_q;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  // Detect pulse, saturating counter and sticky flag share one edge; an event wins over clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      detect <= 1'b0;
      seen   <= 1'b0;
      count  <= '0;
    end else begin
      detect <= event_q;
      if (event_q) begin
        seen <= 1'b1;
        if (clear)                count <= CNT_WIDTH'(1);
        else if (count != CNT_MAX) count <= count + CNT_WIDTH'(1);
      end else if (clear) begin
        seen  <= 1'b0;
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/multi_edge_detect.sv
// rtl/multi_edge_detect.sv - CHANNELS independent debounced edge detectors with counters
module multi_edge_detect
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                SYNC_CLK_IN,
  input  logic                RESET_N_IN,
  multi_edge_detect_if.slave  bus
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_ch (
      .clk      (SYNC_CLK_IN),
      .resetn   (RESET_N_IN),
      .async_in (bus.ASYNC_IN[i]),
      .mode     (bus.MODE_IN[2*i +: 2]),
      .clear    (bus.CLEAR_IN[i]),
      .level    (bus.LEVEL_OUT[i]),
      .detect   (bus.DETECT_OUT[i]),
      .seen     (bus.SEEN_OUT[i]),
      .count    (bus.COUNT_OUT[CNT_WIDTH*i +: CNT_WIDTH])
    );
  end

endmodule
